ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 1250, meaning clock-low inhibit time in wb_clk_i cycles (100 us at 12.5 MHz).
REQ-002 SHALL have parameter INHIBIT_BITS, default 11, meaning inhibit counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 187500, meaning maximum wait per device clock edge (15 ms).
REQ-004 SHALL have parameter TIMEOUT_BITS, default 18, meaning timeout counter width.
REQ-005 SHALL have ports: wb_clk_i in 1 system clock; wb_rst_i in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: wb_dat_i in 8 command byte; wb_we_i in 1; wb_stb_i in 1; wb_cyc_i in 1; wb_ack_o out 1.
REQ-007 SHALL have ports: busy_o out 1 transfer in progress; done_o out 1 one-cycle success pulse; err_o out 1 sticky error.
REQ-008 SHALL have ports: ps2_clk_i in 1, ps2_data_i in 1 pad levels; ps2_clk_oe_o out 1, ps2_data_oe_o out 1 (1 = pull line low).

Function
REQ-009 SHALL assert wb_ack_o for exactly one cycle, registered, the cycle after wb_stb_i & wb_cyc_i; it deasserts before any back-to-back strobe is acknowledged again.
REQ-010 SHALL load wb_dat_i on an acknowledged write in IDLE; a write while busy_o=1 is acknowledged, discarded, and sets err_o.
REQ-011 SHALL ignore reads apart from acknowledging them.
REQ-012 SHALL pass ps2_clk_i and ps2_data_i through two-flop synchronisers; a falling edge is synced clock 1 then 0.
REQ-013 SHALL use states IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE.
REQ-014 IDLE->INHIBIT on accepted write; ps2_clk_oe_o=1; counter runs INHIBIT_CYCLES cycles.
REQ-015 INHIBIT->RTS: ps2_data_oe_o=1 (start bit) one cycle before ps2_clk_oe_o=0.
REQ-016 RTS->SHIFT on the first device falling edge; edge counter is 1.
REQ-017 In SHIFT, after falling edges 1..8, ps2_data_oe_o SHALL equal the inverse of data bits 0..7 (LSB first). After edge 9 it SHALL equal the inverse of the odd parity bit (~^data). After edge 10 it SHALL be released (stop bit); the block then enters ACK.
REQ-018 In ACK, the block SHALL sample synced data at falling edge 11. Low means acknowledge and enters RELEASE; high sets err_o and enters RELEASE.
REQ-019 RELEASE->IDLE once synced clock and data are both high. done_o SHALL pulse on that transition only when the transfer was acknowledged.
REQ-020 busy_o SHALL be 1 in every state except IDLE.
REQ-021 Edge counter SHALL be 4 bits and saturate at 11; no wrap.
REQ-022 err_o SHALL clear only on an accepted write in IDLE or on reset.

Reset
REQ-023 On wb_rst_i=0, the block SHALL immediately enter IDLE, and all outputs SHALL be 0 (lines released), including during a transfer.
REQ-024 After reset release, the block SHALL accept a write on the first cycle.

Configuration
REQ-025 With PS2_TX_TIMEOUT_EN defined, the timeout counter SHALL be instantiated. It restarts at entry to RTS and on each falling edge. Reaching TIMEOUT_CYCLES in RTS, SHIFT or ACK sets err_o, releases both lines, and enters RELEASE.
REQ-026 Without PS2_TX_TIMEOUT_EN, no timeout logic SHALL exist and RTS/SHIFT/ACK wait indefinitely.

Structure
REQ-027 Shared package ps2_pkg SHALL hold the state enum, the edge count constants 10 and 11, and the odd-parity function.
REQ-028 Sub-module ps2_sync_edge SHALL hold the two-flop synchroniser and falling-edge detect; it is instantiated once for clock and once for data (level only).

Verification
REQ-029 Write 0xF4; model device clocks 11 edges, acks data low: data bits 0,0,1,0,1,1,1,1, parity 0, stop released; done_o one pulse; err_o=0.
REQ-030 Write 0xED: ps2_clk_oe_o high for exactly 1250 cycles; ps2_data_oe_o rises before clock release; parity bit 1.
REQ-031 Second write 20 cycles after the first: wb_ack_o pulses, err_o=1, the first transfer completes unchanged, and done_o pulses.
REQ-032 Device leaves data high at edge 11: err_o=1, no done_o, IDLE after lines high.
REQ-033 With PS2_TX_TIMEOUT_EN, device stops after edge 4: after 187500 cycles err_o=1, both oe outputs 0, busy_o falls once lines are high.
REQ-034 Assert wb_rst_i=0 at edge 5: all outputs 0 the same cycle; a new write of 0x01 then transfers with parity 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding, frame edge constants and parity helper for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } ps2_state_t;

  localparam logic [3:0] EDGE_STOP = 4'd10;
  localparam logic [3:0] EDGE_ACK  = 4'd11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - single-cycle Wishbone-style command port of the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] wb_dat_i;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_cyc_i;
  logic       wb_ack_o;

  modport master (output wb_dat_i, output wb_we_i, output wb_stb_i, output wb_cyc_i, input wb_ack_o);
  modport slave  (input wb_dat_i, input wb_we_i, input wb_stb_i, input wb_cyc_i, output wb_ack_o);
endinterface

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - two-flop pad synchroniser with falling-edge detect
// Flops reset high so an idle (pulled-up) line never produces a spurious edge.
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_last <= 1'b1;
    end else begin
      r_meta <= i_pad;
      r_sync <= r_meta;
      r_last <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_last & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ack)
// Optional per-edge watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1250,
  parameter int INHIBIT_BITS   = 11,
  parameter int TIMEOUT_CYCLES = 187500,
  parameter int TIMEOUT_BITS   = 18
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  ps2_host_tx_if.slave wb,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe_o,
  output logic         ps2_data_oe_o
);

  ps2_state_t              r_state;
  ps2_state_t              w_state_nxt;
  logic                    r_ack;
  logic [INHIBIT_BITS-1:0] r_inh;
  logic [3:0]              r_edges;
  logic [8:0]              r_shift;
  logic                    r_acked;
  logic                    r_err;

  logic w_req, w_write, w_accept, w_busy_wr;
  logic w_clk_lvl, w_clk_fall, w_data_lvl, w_data_fall_unused;
  logic w_inh_last, w_waiting, w_tmo_hit;
  logic w_clk_oe, w_data_oe, w_done;

  ps2_sync_edge u_sync_clk (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_i),
    .i_pad   (ps2_clk_i),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_i),
    .i_pad   (ps2_data_i),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall_unused)
  );

  // Masking with r_ack keeps a held strobe from being acknowledged twice in a row.
  assign w_req      = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
  assign w_write    = w_req & wb.wb_we_i;
  assign w_accept   = w_write & (r_state == ST_IDLE);
  assign w_busy_wr  = w_write & (r_state != ST_IDLE);
  assign w_inh_last = (r_state == ST_INHIBIT) && (r_inh == INHIBIT_BITS'(INHIBIT_CYCLES - 1));
  assign w_waiting  = (r_state == ST_RTS) || (r_state == ST_SHIFT) || (r_state == ST_ACK);

`ifdef PS2_TX_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] r_tmo;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_tmo <= '0;
    end else if (w_inh_last || w_clk_fall) begin
      r_tmo <= '0;
    end else if (w_waiting) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo_hit = w_waiting & ~w_clk_fall & (r_tmo == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_tmo_cfg = TIMEOUT_CYCLES + TIMEOUT_BITS;
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clk_oe    = 1'b0;
    w_data_oe   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        w_clk_oe = 1'b1;
        // Start bit goes down while the clock is still held, one cycle ahead of release.
        if (w_inh_last) begin
          w_data_oe   = 1'b1;
          w_state_nxt = ST_RTS;
        end
      end
      ST_RTS: begin
        w_data_oe = 1'b1;
        if (w_clk_fall) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_data_oe = ~r_shift[0];
        if (w_clk_fall && (r_edges == (EDGE_STOP - 4'd1))) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (w_clk_fall) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_clk_lvl && w_data_lvl) begin
          w_state_nxt = ST_IDLE;
          w_done      = r_acked;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_tmo_hit) begin
      w_state_nxt = ST_RELEASE;
      w_clk_oe    = 1'b0;
      w_data_oe   = 1'b0;
    end
  end

  // r_shift holds {parity, data}; each falling edge in SHIFT exposes the next bit at [0].
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_ack   <= 1'b0;
      r_inh   <= '0;
      r_edges <= 4'd0;
      r_shift <= 9'd0;
      r_acked <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_accept) begin
        r_inh   <= '0;
        r_edges <= 4'd0;
        r_shift <= {odd_parity(wb.wb_dat_i), wb.wb_dat_i};
        r_acked <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        if (r_state == ST_INHIBIT) r_inh <= r_inh + 1'b1;
        if (w_waiting && w_clk_fall && (r_edges != EDGE_ACK)) r_edges <= r_edges + 4'd1;
        if ((r_state == ST_SHIFT) && w_clk_fall) r_shift <= {1'b0, r_shift[8:1]};
        if ((r_state == ST_ACK) && w_clk_fall) begin
          if (!w_data_lvl) r_acked <= 1'b1;
          else             r_err   <= 1'b1;
        end
        if (w_busy_wr || w_tmo_hit) r_err <= 1'b1;
      end
    end
  end

  assign wb.wb_ack_o   = r_ack;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = w_done;
  assign err_o         = r_err;
  assign ps2_clk_oe_o  = w_clk_oe;
  assign ps2_data_oe_o = w_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench: open-drain device model captures frames, monitor compares against queued expectations
module tb_ps2_host_tx;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO = 3000;
`else
  localparam int TMO = 187500;
`endif
  localparam int HALF  = 20;
  localparam int LIMIT = 6000;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, done, err, clk_oe, data_oe;
  logic dev_clk, dev_data;
  wire  pad_clk  = dev_clk & ~clk_oe;
  wire  pad_data = dev_data & ~data_oe;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  ps2_host_tx_if wb ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (1250),
    .INHIBIT_BITS   (11),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_BITS   (18)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst_n),
    .wb            (wb),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .ps2_clk_i     (pad_clk),
    .ps2_data_i    (pad_data),
    .ps2_clk_oe_o  (clk_oe),
    .ps2_data_oe_o (data_oe)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endfunction

  // Line levels of the frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wb.wb_ack_o) ack_cnt++;
    if (obs_q.size() > 0) begin
      logic [10:0] f;
      f = obs_q.pop_front();
      if (exp_q.size() == 0) check("frame_unexpected", {21'd0, f}, 32'hFFFF_FFFF);
      else                   check("frame", {21'd0, f}, {21'd0, exp_q.pop_front()});
    end
  end

  task automatic wb_write(input logic [7:0] d);
    int n;
    wb.wb_dat_i = d;
    wb.wb_we_i  = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.wb_ack_o && n < 8);
    check("wb_ack", {31'd0, wb.wb_ack_o}, 32'd1);
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic device(input int nedges, input bit do_ack, input bit push);
    logic [10:0] f;
    logic dlast;
    int n;
    f = '0;
    dlast = 1'b0;
    n = 0;
    while (clk_oe !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      check("inhibit_start_timeout", 32'd0, 32'd1);
      return;
    end
    n = 0;
    while (clk_oe === 1'b1 && n < LIMIT) begin
      n++;
      dlast = data_oe;
      @(negedge clk);
    end
    check("inhibit_len", n, 32'd1250);
    check("start_before_release", {31'd0, dlast}, 32'd1);
    check("rts_data_oe", {31'd0, data_oe}, 32'd1);
    repeat (10) @(negedge clk);
    f[0] = pad_data;
    for (int e = 1; e <= nedges; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (e <= 10) f[e] = pad_data;
      if (e == 10 && do_ack) dev_data = 1'b0;
    end
    dev_data = 1'b1;
    if (push) obs_q.push_back(f);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_transfer(input logic [7:0] d, input bit do_ack);
    int d0;
    d0 = done_cnt;
    exp_q.push_back(model_frame(d));
    fork
      wb_write(d);
      device(11, do_ack, 1'b1);
    join
    wait_idle();
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, do_ack ? 32'd1 : 32'd0);
    check("err", {31'd0, err}, do_ack ? 32'd0 : 32'd1);
    check("lines_released", {30'd0, clk_oe, data_oe}, 32'd0);
  endtask

  initial begin
    int d0, a0;
    rst_n = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    wb.wb_dat_i = 8'h00;
    wb.wb_we_i  = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {26'd0, wb.wb_ack_o, busy, done, err, clk_oe, data_oe}, 32'd0);

    // Write presented in the very first cycle after reset release.
    rst_n = 1'b1;
    do_transfer(8'hF4, 1'b1);
    @(negedge clk);
    do_transfer(8'hED, 1'b1);

    // Write while busy: acknowledged, dropped, sets err; first transfer unaffected.
    @(negedge clk);
    d0 = done_cnt;
    a0 = ack_cnt;
    exp_q.push_back(model_frame(8'h3A));
    fork
      begin
        wb_write(8'h3A);
        repeat (20) @(negedge clk);
        wb_write(8'hC5);
      end
      device(11, 1'b1, 1'b1);
    join
    wait_idle();
    repeat (3) @(negedge clk);
    check("busy_wr_acks", ack_cnt - a0, 32'd2);
    check("busy_wr_err", {31'd0, err}, 32'd1);
    check("busy_wr_done", done_cnt - d0, 32'd1);

    // Device nack, then randomized traffic.
    @(negedge clk);
    do_transfer(8'h5B, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      bit a;
      d = 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      do_transfer(d, a);
    end

    // Reset in the middle of the frame, right after edge 5.
    @(negedge clk);
    fork
      wb_write(8'h2C);
      device(5, 1'b0, 1'b0);
    join
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    check("mid_frame_bit4", {31'd0, data_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", {26'd0, wb.wb_ack_o, busy, done, err, clk_oe, data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_transfer(8'h01, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
    // Device goes silent after edge 4.
    @(negedge clk);
    d0 = done_cnt;
    fork
      wb_write(8'hA5);
      device(4, 1'b0, 1'b0);
    join
    begin
      int n;
      n = 0;
      while (err !== 1'b1 && n < TMO + 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_lines", {30'd0, clk_oe, data_oe}, 32'd0);
    wait_idle();
    check("tmo_no_done", done_cnt - d0, 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
